// File: rtl/heap_cmd_issuer.sv
// Command feeder for the heap SIMD unit: buffers push/pop commands, rejects
// overflow/underflow against a shadow occupancy, and issues one rd strobe at a time.
module heap_cmd_issuer #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int HEAP_SIZE  = 25,
  parameter int NOP_RD     = 31
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_op,
  input  logic [DATA_W-1:0]               cmd_data,
  output logic [4:0]                      heap_rd,
  output logic [DATA_W-1:0]               heap_data,
  input  logic                            heap_idle,
  output logic                            err_valid,
  output logic [1:0]                      err_code,
  output logic [$clog2(HEAP_SIZE+1)-1:0]  occupancy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  // state | meaning
  // IDLE  | waiting for a buffered command; dequeues and issues or drops it
  // ISSUE | heap_rd carries the command for exactly this cycle
  // WAIT  | heap busy; return to IDLE once heap_idle is seen
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int OCC_W = $clog2(HEAP_SIZE+1);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(HEAP_SIZE);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [4:0]       NOP      = 5'(NOP_RD);

  state_t state, state_nxt;

  logic [DATA_W:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wptr, rptr;
  logic               enq, deq, drop, issue;
  logic               head_op;
  logic [DATA_W-1:0]  head_data;
  logic [4:0]         rd_nxt;
  logic [DATA_W-1:0]  data_nxt;
  logic               err_valid_nxt;
  logic [1:0]         err_code_nxt;
  logic [OCC_W-1:0]   occ_nxt;

  assign cmd_ready = (fifo_count != CNT_FULL);
  assign enq       = cmd_valid && cmd_ready;
  assign deq       = (state == IDLE) && (fifo_count != '0);
  assign head_op   = mem[rptr][DATA_W];
  assign head_data = mem[rptr][DATA_W-1:0];
  assign drop      = deq && ((!head_op && occupancy == OCC_MAX) ||
                             ( head_op && occupancy == '0));
  assign issue     = deq && !drop;

  always_ff @(posedge clk) begin
    if (enq) mem[wptr] <= {cmd_op, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      heap_rd    <= NOP;
      heap_data  <= '0;
      err_valid  <= 1'b0;
      err_code   <= 2'd0;
      occupancy  <= '0;
    end else begin
      state     <= state_nxt;
      heap_rd   <= rd_nxt;
      heap_data <= data_nxt;
      err_valid <= err_valid_nxt;
      err_code  <= err_code_nxt;
      occupancy <= occ_nxt;
      if (enq) wptr <= wptr + PTR_W'(1);
      if (deq) rptr <= rptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (heap_idle) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Only an IDLE dequeue that passes the occupancy check drives a real rd code.
  always_comb begin
    rd_nxt        = NOP;
    data_nxt      = '0;
    err_valid_nxt = drop;
    err_code_nxt  = 2'd0;
    occ_nxt       = occupancy;
    if (drop) err_code_nxt = head_op ? 2'd2 : 2'd1;
    if (issue) begin
      rd_nxt = {4'b0000, head_op};
      if (head_op) begin
        occ_nxt = occupancy - OCC_W'(1);
      end else begin
        data_nxt = head_data;
        occ_nxt  = occupancy + OCC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_heap_cmd_issuer.sv
// Directed bench for heap_cmd_issuer: a scoreboard queue holds expected issues
// and expected drops; a small heap model answers heap_idle two cycles after each issue.
module tb_heap_cmd_issuer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [31:0] cmd_data = '0;
  logic [4:0]  heap_rd;
  logic [31:0] heap_data;
  logic        heap_idle = 1'b1;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [4:0]  occupancy;
  logic [3:0]  fifo_count;

  int tests = 0;
  int failed = 0;
  logic [32:0] exp_q[$];
  logic [1:0]  err_q[$];
  int model_occ = 0;
  int busy = 0;
  logic hold = 1'b0;

  heap_cmd_issuer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .heap_rd(heap_rd), .heap_data(heap_data),
    .heap_idle(heap_idle), .err_valid(err_valid), .err_code(err_code),
    .occupancy(occupancy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Heap model: busy for two cycles after each strobe.
  always @(negedge clk) begin
    if (reset) busy = 0;
    else if (heap_rd != 5'd31) busy = 2;
    else if (busy > 0) busy--;
    heap_idle = !hold && (busy == 0);
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset && heap_rd !== 5'd31) begin
      if (exp_q.size() == 0) check("spurious_issue", 64'(heap_rd), 64'd31);
      else begin
        e = exp_q.pop_front();
        check("issue_op", 64'(heap_rd), 64'(e[32]));
        check("issue_data", 64'(heap_data), 64'(e[31:0]));
      end
    end
    if (!reset && err_valid === 1'b1) begin
      if (err_q.size() == 0) check("spurious_err", 64'(err_code), 64'd0);
      else check("err_code", 64'(err_code), 64'(err_q.pop_front()));
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    err_q.delete();
    model_occ = 0;
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic op, input logic [31:0] d);
    int t = 0;
    while (!cmd_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("ready_timeout", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    if (!op && model_occ == 25) err_q.push_back(2'd1);
    else if (op && model_occ == 0) err_q.push_back(2'd2);
    else begin
      exp_q.push_back({op, op ? 32'd0 : d});
      model_occ += op ? -1 : 1;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0 || fifo_count != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 64'(t < budget), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    // T1 reset
    do_reset();
    check("t1_heap_rd", 64'(heap_rd), 64'd31);
    check("t1_heap_data", 64'(heap_data), 64'd0);
    check("t1_cmd_ready", 64'(cmd_ready), 64'd1);
    check("t1_occupancy", 64'(occupancy), 64'd0);
    check("t1_err_valid", 64'(err_valid), 64'd0);
    check("t1_err_code", 64'(err_code), 64'd0);
    check("t1_fifo_count", 64'(fifo_count), 64'd0);

    // T2 single push, exact latency
    send(1'b0, 32'h10);
    check("t2_not_yet", 64'(heap_rd), 64'd31);
    @(negedge clk);
    check("t2_rd", 64'(heap_rd), 64'd0);
    check("t2_data", 64'(heap_data), 64'h10);
    @(negedge clk);
    check("t2_rd_after", 64'(heap_rd), 64'd31);
    check("t2_occ", 64'(occupancy), 64'd1);
    drain(50);

    // T3 pop on empty
    do_reset();
    send(1'b1, 32'h0);
    @(negedge clk);
    check("t3_err_valid", 64'(err_valid), 64'd1);
    check("t3_err_code", 64'(err_code), 64'd2);
    check("t3_rd", 64'(heap_rd), 64'd31);
    @(negedge clk);
    check("t3_err_pulse", 64'(err_valid), 64'd0);
    check("t3_occ", 64'(occupancy), 64'd0);

    // T4 fill to capacity, overflow, then pop
    do_reset();
    for (int i = 0; i < 25; i++) send(1'b0, 32'h200 + 32'(i));
    drain(1000);
    check("t4_occ_full", 64'(occupancy), 64'd25);
    send(1'b0, 32'hdead);
    drain(50);
    check("t4_occ_after_drop", 64'(occupancy), 64'd25);
    send(1'b1, 32'h0);
    drain(50);
    check("t4_occ_after_pop", 64'(occupancy), 64'd24);

    // T5 backpressure with the heap held busy
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 9; i++) send(1'b0, 32'h100 + 32'(i));
    check("t5_ready_low", 64'(cmd_ready), 64'd0);
    check("t5_fifo_full", 64'(fifo_count), 64'd8);
    check("t5_one_issued", 64'(exp_q.size()), 64'd8);
    hold = 1'b0;
    drain(300);
    check("t5_occ", 64'(occupancy), 64'd9);

    // T6 reset while in WAIT with commands queued
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, 32'h300 + 32'(i));
    @(negedge clk);
    check("t6_first_issued", 64'(exp_q.size()), 64'd3);
    check("t6_queued", 64'(fifo_count), 64'd3);
    do_reset();
    check("t6_fifo_count", 64'(fifo_count), 64'd0);
    check("t6_rd", 64'(heap_rd), 64'd31);
    check("t6_occ", 64'(occupancy), 64'd0);
    hold = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_still_empty", 64'(fifo_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
